// File: rtl/alu_arbiter_pkg.sv
// ============================================================================
// Module : alu_arbiter_pkg
// Brief  : Shared ALU op codes, zero constant and arbiter state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arbiter_pkg;

  localparam logic [3:0]  ALU_AND  = 4'd0;
  localparam logic [3:0]  ALU_OR   = 4'd1;
  localparam logic [3:0]  ALU_ADD  = 4'd2;
  localparam logic [3:0]  ALU_SLL  = 4'd3;
  localparam logic [3:0]  ALU_SUB  = 4'd6;
  localparam logic [3:0]  ALU_NONE = 4'd15;

  localparam logic [31:0] ZERO     = 32'd0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin selector; searches from last+1 with wrap.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  // Distance k from the last winner sets priority; k = N wraps back to last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any_o && req_i[i] && (((int'(last_i) + k) % N) == i)) begin
          gnt_o[i] = 1'b1;
          idx_o    = IDW'(i);
          any_o    = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module : alu_arbiter
// Brief  : Round-robin sharing of one combinational ALU with registered
//          operands/result. Optional grant counters via ALU_ARB_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][3:0]  req_op,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [31:0]              rsp_result,
  output logic                     rsp_zero,
  output logic [IDW-1:0]           rsp_id,
  output logic [3:0]               alu_operation,
  output logic [31:0]              alu_operand_a,
  output logic [31:0]              alu_operand_b,
  input  logic [31:0]              alu_result,
  input  logic                     alu_result_zero,
  output logic [NUM_REQ-1:0][15:0] stat_grants
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      res_q, res_d;
  logic             zero_q, zero_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  rr_picker #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_picker (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    id_d          = id_q;
    rsp_id_d      = rsp_id_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    zero_d        = zero_q;
    req_ready     = '0;
    rsp_valid     = '0;
    alu_operation = ALU_NONE;
    alu_operand_a = ZERO;
    alu_operand_b = ZERO;
    case (state_q)
      ARB_IDLE: begin
        req_ready = pick_gnt;
        if (pick_any) begin
          op_d    = req_op[pick_idx];
          a_d     = req_a[pick_idx];
          b_d     = req_b[pick_idx];
          id_d    = pick_idx;
          last_d  = pick_idx;
          state_d = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        alu_operation = op_q;
        alu_operand_a = a_q;
        alu_operand_b = b_q;
        res_d         = alu_result;
        zero_d        = alu_result_zero;
        rsp_id_d      = id_q;
        state_d       = ARB_RESP;
      end
      ARB_RESP: begin
        rsp_valid[rsp_id_q] = 1'b1;
        if (rsp_ready[rsp_id_q]) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      last_q   <= IDW'(NUM_REQ - 1);
      id_q     <= '0;
      rsp_id_q <= '0;
      op_q     <= ALU_NONE;
      a_q      <= ZERO;
      b_q      <= ZERO;
      res_q    <= ZERO;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      rsp_id_q <= rsp_id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
    end
  end

  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_id     = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    // A grant in IDLE is always a handshake since the winner is valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[g] <= '0;
      end else if ((state_q == ARB_IDLE) && pick_gnt[g] && (cnt_q[g] != 16'hFFFF)) begin
        cnt_q[g] <= cnt_q[g] + 16'd1;
      end
    end
    assign stat_grants[g] = cnt_q[g];
  end
`else
  assign stat_grants = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module : tb_alu_arbiter
// Brief  : Self-checking bench for alu_arbiter (NUM_REQ = 2) with an ALU model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][3:0]  req_op;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic [0:0]       rsp_id;
  logic [3:0]       alu_operation;
  logic [31:0]      alu_operand_a;
  logic [31:0]      alu_operand_b;
  logic [31:0]      alu_result;
  logic             alu_result_zero;
  logic [1:0][15:0] stat_grants;

  int n_chk  = 0;
  int n_pass = 0;

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_a           (req_a),
    .req_b           (req_b),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_result      (rsp_result),
    .rsp_zero        (rsp_zero),
    .rsp_id          (rsp_id),
    .alu_operation   (alu_operation),
    .alu_operand_a   (alu_operand_a),
    .alu_operand_b   (alu_operand_b),
    .alu_result      (alu_result),
    .alu_result_zero (alu_result_zero),
    .stat_grants     (stat_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_operation)
      ALU_AND: alu_result = alu_operand_a & alu_operand_b;
      ALU_OR:  alu_result = alu_operand_a | alu_operand_b;
      ALU_ADD: alu_result = alu_operand_a + alu_operand_b;
      ALU_SUB: alu_result = alu_operand_a - alu_operand_b;
      ALU_SLL: alu_result = alu_operand_a << alu_operand_b[4:0];
      default: alu_result = ZERO;
    endcase
    alu_result_zero = (alu_result == ZERO);
  end

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Full transaction from IDLE: grant at T, ALU drive at T+1, response at T+2.
  task automatic single_op(input int id, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic ez);
    @(negedge clk);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    req_a[id]     = a;
    req_b[id]     = b;
    #1 chk("grant", req_ready, 64'(1 << id));
    @(negedge clk);
    req_valid = '0;
    chk("alu_op", alu_operation, op);
    chk("alu_a", alu_operand_a, a);
    chk("alu_b", alu_operand_b, b);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 64'(1 << id));
    chk("rsp_result", rsp_result, er);
    chk("rsp_zero", rsp_zero, ez);
    chk("rsp_id", rsp_id, id);
    rsp_ready     = '0;
    rsp_ready[id] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    chk("rsp_drop", rsp_valid, 0);
    chk("alu_idle", alu_operation, ALU_NONE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int ng, last_t, exp_id, eid;

    vecs[0] = '{0, ALU_ADD, 32'd5,         32'd7,         32'd12,        1'b0};
    vecs[1] = '{1, ALU_SUB, 32'd9,         32'd9,         32'd0,         1'b1};
    vecs[2] = '{0, ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0};
    vecs[3] = '{1, ALU_OR,  32'd1,         32'd2,         32'd3,         1'b0};
    vecs[4] = '{0, ALU_SLL, 32'd1,         32'd4,         32'd16,        1'b0};
    vecs[5] = '{1, 4'hD,    32'd3,         32'd4,         32'd0,         1'b1};
    vecs[6] = '{0, ALU_SUB, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0};

    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    do_reset();

    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_alu_op", alu_operation, ALU_NONE);
    chk("rst_alu_a", alu_operand_a, 0);
    chk("rst_stats", stat_grants, 0);

    for (int i = 0; i < 7; i++)
      single_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z);

    // Round robin with both requesters held valid and responses always accepted.
    do_reset();
    req_op[0] = ALU_AND; req_a[0] = 32'd12; req_b[0] = 32'd10;
    req_op[1] = ALU_OR;  req_a[1] = 32'd12; req_b[1] = 32'd10;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    ng = 0; last_t = 0; exp_id = 0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("rr_grant", req_ready, 64'(1 << exp_id));
        if (ng > 0) chk("rr_spacing", 64'(cyc - last_t), 3);
        q.push_back(exp_id);
        last_t = cyc;
        ng++;
        exp_id ^= 1;
      end
      if (rsp_valid != 2'b00) begin
        eid = (q.size() > 0) ? q.pop_front() : -1;
        chk("rr_rsp_id", rsp_id, 64'(eid));
        chk("rr_rsp_valid", rsp_valid, 64'(1 << eid));
        chk("rr_rsp_result", rsp_result, (eid == 1) ? 64'd14 : 64'd8);
      end
      @(negedge clk);
    end
    chk("rr_grant_count", ng, 4);

    // Response backpressure holds the response and blocks the pending request.
    do_reset();
    req_op[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd1;
    req_op[1] = ALU_SUB; req_a[1] = 32'd5; req_b[1] = 32'd3;
    req_valid = 2'b11;
    #1 chk("bp_grant0", req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp_rsp_valid", rsp_valid, 2'b01);
    chk("bp_rsp_result", rsp_result, 2);
    rsp_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 2'b01);
      chk("bp_hold_result", rsp_result, 2);
      chk("bp_no_grant", req_ready, 0);
    end
    rsp_ready = 2'b01;
    #1 chk("bp_no_grant_ack", req_ready, 0);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 chk("bp_grant1", req_ready, 2'b10);
    chk("bp_rsp_clear", rsp_valid, 0);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("bp_rsp1_valid", rsp_valid, 2'b10);
    chk("bp_rsp1_result", rsp_result, 2);
    chk("bp_rsp1_id", rsp_id, 1);
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;

    // Reset during EXEC discards the operation.
    do_reset();
    req_op[0] = ALU_SLL; req_a[0] = 32'd1; req_b[0] = 32'd4;
    req_valid = 2'b01;
    #1 chk("re_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    chk("re_exec_op", alu_operation, ALU_SLL);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("re_rsp_valid", rsp_valid, 0);
    chk("re_rsp_result", rsp_result, 0);
    chk("re_rsp_zero", rsp_zero, 0);
    chk("re_rsp_id", rsp_id, 0);
    chk("re_alu_op", alu_operation, ALU_NONE);
    chk("re_req_ready", req_ready, 0);
    repeat (3) begin
      @(negedge clk);
      chk("re_no_rsp", rsp_valid, 0);
    end
    req_op[0] = ALU_ADD; req_op[1] = ALU_ADD;
    req_valid = 2'b11;
    #1 chk("re_first_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 2'b11;
    @(negedge clk);
    rsp_ready = 2'b00;

    // Grant counters: 5 to req0, 3 to req1.
    do_reset();
    chk("st_clear", stat_grants, 0);
    for (int k = 0; k < 5; k++)
      single_op(0, ALU_ADD, 32'(k), 32'd1, 32'(k + 1), 1'b0);
    for (int k = 0; k < 3; k++)
      single_op(1, ALU_ADD, 32'(k), 32'd2, 32'(k + 2), 1'b0);
`ifdef ALU_ARB_STATS_EN
    chk("st_counts", stat_grants, {16'd3, 16'd5});
`else
    chk("st_counts", stat_grants, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
